// File: rtl/afifo_tb_pkg.sv
// Shared definitions for the async FIFO read-side drainer: data width, FSM
// state encodings and the throttle LFSR constants.
package afifo_tb_pkg;

    localparam int DATA_WIDTH = 8;

    typedef logic [1:0] drainer_state_e;
    localparam drainer_state_e IDLE = 2'd0;
    localparam drainer_state_e ARM  = 2'd1;
    localparam drainer_state_e READ = 2'd2;
    localparam drainer_state_e DONE = 2'd3;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // One step of the right-shifting Galois LFSR
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/afifo_rd_throttle.sv
// Read-gap generator for the drainer. AFIFO_RD_DRAIN_LFSR_EN selects a random
// LFSR duty; otherwise a deterministic 2-on/1-off pattern is used.
module afifo_rd_throttle (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic ok_o
);
    import afifo_tb_pkg::*;

    logic pattern;

`ifdef AFIFO_RD_DRAIN_LFSR_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign lfsr_d  = lfsr_step(lfsr_q);
    assign pattern = lfsr_q[0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) lfsr_q <= LFSR_SEED;
        else         lfsr_q <= lfsr_d;
    end
`else
    logic [1:0] ph_q, ph_d;

    assign ph_d    = (ph_q == 2'd2) ? 2'd0 : ph_q + 2'd1;
    assign pattern = (ph_q != 2'd2);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ph_q <= '0;
        else         ph_q <= ph_d;
    end
`endif

    assign ok_o = !en_i || pattern;

endmodule

// File: rtl/afifo_rd_drainer.sv
// Read-port consumer for the async FIFO: drives rinc, checks rdata against an
// incrementing sequence and keeps statistics. Throttle mode via AFIFO_RD_DRAIN_LFSR_EN.
module afifo_rd_drainer #(
    parameter int DATA_WIDTH = afifo_tb_pkg::DATA_WIDTH,
    parameter int CNT_WIDTH  = 16,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  num_reads,
    input  logic [DATA_WIDTH-1:0] exp_seed,
    input  logic                  throttle_en,
    input  logic                  rempty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rinc,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic [CNT_WIDTH-1:0]  poll_count,
    output logic [DATA_WIDTH-1:0] first_err_data
);
    import afifo_tb_pkg::*;

    localparam int STALL_W = $clog2(TIMEOUT + 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    drainer_state_e        state_q, state_d;
    logic [CNT_WIDTH-1:0]  rem_q, rem_d, rem_after;
    logic [DATA_WIDTH-1:0] exp_q, exp_d;
    logic [CNT_WIDTH-1:0]  rd_q, rd_d, err_q, err_d, poll_q, poll_d;
    logic [DATA_WIDTH-1:0] ferr_q, ferr_d;
    logic [STALL_W-1:0]    stall_q, stall_d;
    logic                  to_q, to_d, rinc_q, rinc_d;
    logic                  accept, throttle_ok;

    afifo_rd_throttle u_throttle (
        .clk_i  (rclk),
        .rst_ni (rrst_n),
        .en_i   (throttle_en),
        .ok_o   (throttle_ok)
    );

    assign accept    = rinc_q && !rempty;
    assign rem_after = accept ? rem_q - 1'b1 : rem_q;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_after;
        exp_d   = exp_q;
        rd_d    = rd_q;
        err_d   = err_q;
        poll_d  = poll_q;
        ferr_d  = ferr_q;
        to_d    = to_q;
        stall_d = stall_q;

        if (accept) begin
            rd_d  = sat_inc(rd_q);
            exp_d = exp_q + 1'b1;
            if (rdata != exp_q) begin
                err_d = sat_inc(err_q);
                if (err_q == '0) ferr_d = rdata;
            end
        end
        if (rinc_q && rempty) poll_d = sat_inc(poll_q);

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = ARM;
                    rem_d   = num_reads;
                    exp_d   = exp_seed;
                end
            end
            ARM: begin
                rd_d    = '0;
                err_d   = '0;
                poll_d  = '0;
                ferr_d  = '0;
                to_d    = 1'b0;
                stall_d = '0;
                state_d = (rem_q == '0) ? DONE : READ;
            end
            READ: begin
                if (accept) begin
                    stall_d = '0;
                    if (rem_after == '0) state_d = DONE;
                end else begin
                    stall_d = stall_q + 1'b1;
                    if (stall_d == STALL_MAX) begin
                        state_d = DONE;
                        to_d    = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Looks at the post-accept remaining count so rinc drops right after the last read
        rinc_d = (state_d == READ) && (rem_after != '0) && throttle_ok;
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            exp_q   <= '0;
            rd_q    <= '0;
            err_q   <= '0;
            poll_q  <= '0;
            ferr_q  <= '0;
            stall_q <= '0;
            to_q    <= 1'b0;
            rinc_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            exp_q   <= exp_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            poll_q  <= poll_d;
            ferr_q  <= ferr_d;
            stall_q <= stall_d;
            to_q    <= to_d;
            rinc_q  <= rinc_d;
        end
    end

    assign rinc           = rinc_q;
    assign busy           = (state_q == ARM) || (state_q == READ);
    assign done           = (state_q == DONE);
    assign timeout        = to_q;
    assign rd_count       = rd_q;
    assign err_count      = err_q;
    assign poll_count     = poll_q;
    assign first_err_data = ferr_q;

endmodule

// File: doc/afifo_rd_drainer.md
Name: afifo_rd_drainer

Overview:
- Synthesizable read-side consumer on the async FIFO read port, in the rclk domain.
- Drives rinc, which is the only FIFO input it drives.
- On each accepted read, compares rdata against an expected incrementing sequence.
- Keeps read, mismatch and empty-poll statistics for the bench, and sits alongside the read monitor as the read-port stimulus source.

Parameters:
- DATA_WIDTH, 8, width of rdata and of the expected-data register.
- CNT_WIDTH, 16, width of num_reads and of all counters.
- TIMEOUT, 1024, consecutive stalled cycles in READ before the run is aborted.

Ports:
- rclk  in  1  read clock.
- rrst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a run; ignored unless in IDLE or DONE.
- num_reads  in  CNT_WIDTH  reads to perform; sampled on start.
- exp_seed  in  DATA_WIDTH  first expected word; sampled on start.
- throttle_en  in  1  1 = pseudo-random gaps on rinc; 0 = rinc held high in READ.
- rempty  in  1  FIFO empty flag.
- rdata  in  DATA_WIDTH  FIFO read data, valid while !rempty.
- rinc  out  1  FIFO read increment, registered.
- busy  out  1  high in ARM and READ.
- done  out  1  high in DONE.
- timeout  out  1  sticky; the run ended by timeout.
- rd_count  out  CNT_WIDTH  accepted reads.
- err_count  out  CNT_WIDTH  data mismatches.
- poll_count  out  CNT_WIDTH  cycles with rinc && rempty.
- first_err_data  out  DATA_WIDTH  rdata at the first mismatch.

Behaviour:
- Reset (async, rrst_n low): state = IDLE; all outputs 0; expected = 0; LFSR = non-zero constant.
- Accept: a read is accepted on a rclk posedge where rinc && !rempty.
  - On accept, rdata is compared to expected, then expected increments by 1, wrapping mod 2^DATA_WIDTH (0xFF -> 0x00 at width 8).
  - Mismatch: err_count +1; first_err_data is captured only when err_count was 0.
  - rd_count +1 on every accept.
- Polls: rinc && rempty at a posedge counts in poll_count; no other effect.
- Counters saturate at all-ones.
- FSM:
  - IDLE --start--> ARM.
  - ARM (1 cycle): load expected = exp_seed and remaining = num_reads; clear the counters and timeout. Go to DONE if num_reads == 0, else READ.
  - READ: go to DONE when the accept that brings remaining to 0 occurs. Also go to DONE with timeout = 1 when the stall counter reaches TIMEOUT.
  - DONE --start--> ARM. Counters hold until the next ARM.
- rinc_next = (next state is READ) && (remaining after this cycle's accept > 0) && throttle_ok.
  - rinc therefore drops in the cycle after the final accept, so the FIFO never sees an extra read.
- throttle_ok = 1 when throttle_en = 0; otherwise as defined under Optional Feature.
- Stall counter: increments each READ cycle without an accept; clears on accept and in ARM.
- start while busy is ignored.
- rrst_n asserted mid-run: immediate return to IDLE; rinc = 0 asynchronously.

Optional Feature:
- Macro AFIFO_RD_DRAIN_LFSR_EN.
- Defined: throttle_ok = bit 0 of a 16-bit Galois LFSR (taps 0xB400) that advances every rclk cycle. This gives a random read duty of about 50%.
- Undefined: throttle_ok follows a fixed pattern of 2 cycles on, 1 cycle off from a mod-3 counter, which is deterministic.
- In both cases throttle_en = 0 forces throttle_ok = 1.

Decomposition:
- Shared package afifo_tb_pkg holds:
  - DATA_WIDTH;
  - the drainer_state_e typedef (IDLE, ARM, READ, DONE);
  - LFSR_SEED (16'hACE1) and LFSR_TAPS.
- Natural sub-module: afifo_rd_throttle, which contains the LFSR or mod-3 pattern and outputs throttle_ok.

Test Plan:
- num_reads = 4, exp_seed = 0x10, FIFO preloaded 0x10..0x13, throttle_en = 0 -> rinc high exactly 4 cycles; rd_count = 4, err_count = 0, done = 1, no read after the 4th accept.
- Same run with FIFO preloaded 0x10, 0x11, 0x55, 0x13 -> err_count = 1, first_err_data = 0x55, rd_count = 4.
- exp_seed = 0xFE, num_reads = 3, FIFO 0xFE, 0xFF, 0x00 -> err_count = 0 (wrap).
- Empty FIFO, num_reads = 2, TIMEOUT = 16 -> timeout = 1 and DONE after 16 stalled cycles; poll_count = 16; rd_count = 0.
- num_reads = 0 -> ARM then DONE; rinc never asserted.
- rrst_n pulsed low mid-READ with throttle_en = 1 -> rinc = 0 at once, state = IDLE, all counters 0; a new start runs cleanly.
